// File: rtl/sdram_responder.sv
// sdram_responder: device-side SDR SDRAM for controller loopback.
// Decodes the command pins, tracks banks/mode and serves reads after CL.
module sdram_responder #(
  parameter int BANK_WIDTH     = 2,
  parameter int ROW_WIDTH      = 13,
  parameter int COL_WIDTH      = 9,
  parameter int DATA_WIDTH     = 16,
  parameter int MEM_ADDR_WIDTH = 10,
  parameter int T_RCD          = 2,
  parameter int T_RP           = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [ROW_WIDTH-1:0]    io_sdram_ADDR,
  input  logic [BANK_WIDTH-1:0]   io_sdram_BA,
  input  logic [DATA_WIDTH-1:0]   io_sdram_DQ_read,
  output logic [DATA_WIDTH-1:0]   io_sdram_DQ_write,
  output logic                    io_sdram_DQ_writeEnable,
  input  logic [DATA_WIDTH/8-1:0] io_sdram_DQM,
  input  logic                    io_sdram_CASn,
  input  logic                    io_sdram_RASn,
  input  logic                    io_sdram_WEn,
  input  logic                    io_sdram_CSn,
  input  logic                    io_sdram_CKE,
  output logic                    io_modeLoaded,
  output logic                    io_error
);

  localparam int NB    = 1 << BANK_WIDTH;
  localparam int NBYTE = DATA_WIDTH / 8;
  localparam int DEPTH = 1 << MEM_ADDR_WIDTH;
  localparam int CMAX  = (T_RCD > T_RP) ? T_RCD : T_RP;
  localparam int CNT_W = $clog2(CMAX + 1);

  localparam logic [3:0] CMD_LMR = 4'b0000;
  localparam logic [3:0] CMD_REF = 4'b0001;
  localparam logic [3:0] CMD_PRE = 4'b0010;
  localparam logic [3:0] CMD_ACT = 4'b0011;
  localparam logic [3:0] CMD_WR  = 4'b0100;
  localparam logic [3:0] CMD_RD  = 4'b0101;
  localparam logic [3:0] CMD_NOP = 4'b0111;

  logic [NB-1:0]         r_open;
  logic [ROW_WIDTH-1:0]  r_row [NB];
  logic [CNT_W-1:0]      r_cnt [NB];
  logic                  r_cl3;
  logic                  r_mode;
  logic                  r_err;
  logic                  r_d_v;
  logic [DATA_WIDTH-1:0] r_d_q;
  logic                  r_s_v;
  logic [DATA_WIDTH-1:0] r_s_q;
  logic                  r_we;
  logic [DATA_WIDTH-1:0] r_dq;
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  logic [3:0]                w_cmd;
  logic                      w_sel;
  logic                      w_all_idle;
  logic                      w_act_ok;
  logic                      w_rw_ok;
  logic                      w_cl_ok;
  logic [MEM_ADDR_WIDTH-1:0] w_idx;
  logic [DATA_WIDTH-1:0]     w_rdata;
  logic                      w_do_lmr;
  logic                      w_do_act;
  logic                      w_do_rd;
  logic                      w_do_wr;
  logic                      w_do_pre;
  logic                      w_viol;

  assign w_cmd = {io_sdram_CSn, io_sdram_RASn,
                  io_sdram_CASn, io_sdram_WEn};
  assign w_sel = io_sdram_CKE && !io_sdram_CSn;
  assign w_all_idle = (r_open == '0);
  assign w_act_ok = !r_open[io_sdram_BA] &&
                    (r_cnt[io_sdram_BA] == '0);
  assign w_rw_ok  = r_open[io_sdram_BA] &&
                    (r_cnt[io_sdram_BA] == '0);
  assign w_cl_ok  = (io_sdram_ADDR[6:4] == 3'd2) ||
                    (io_sdram_ADDR[6:4] == 3'd3);
  // Storage is a window onto {bank,row,col}; high bits alias.
  assign w_idx = MEM_ADDR_WIDTH'({io_sdram_BA,
                  r_row[io_sdram_BA],
                  io_sdram_ADDR[COL_WIDTH-1:0]});
  assign w_rdata = r_mem[w_idx];

  always_comb begin
    w_do_lmr = 1'b0;
    w_do_act = 1'b0;
    w_do_rd  = 1'b0;
    w_do_wr  = 1'b0;
    w_do_pre = 1'b0;
    w_viol   = 1'b0;
    if (w_sel) begin
      if (!r_mode && w_cmd != CMD_NOP && w_cmd != CMD_LMR) begin
        w_viol = 1'b1;
      end else begin
        case (w_cmd)
          CMD_LMR: begin
            w_do_lmr = w_all_idle;
            w_viol   = !w_all_idle || !w_cl_ok ||
                       (io_sdram_ADDR[2:0] != 3'b000);
          end
          CMD_ACT: begin
            w_do_act = w_act_ok;
            w_viol   = !w_act_ok;
          end
          CMD_RD: begin
            w_do_rd = w_rw_ok;
            w_viol  = !w_rw_ok;
          end
          CMD_WR: begin
            w_do_wr = w_rw_ok;
            w_viol  = !w_rw_ok;
          end
          CMD_PRE: w_do_pre = 1'b1;
          CMD_REF: w_viol = !w_all_idle;
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_mode <= 1'b0;
      r_cl3  <= 1'b1;
      r_err  <= 1'b0;
    end else begin
      if (w_viol) r_err <= 1'b1;
      if (w_do_lmr) r_mode <= 1'b1;
      if (w_do_lmr && w_cl_ok) r_cl3 <= io_sdram_ADDR[4];
    end
  end

  // Counters hold T-1 so a command exactly T edges later sees zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_open <= '0;
      for (int b = 0; b < NB; b++) begin
        r_row[b] <= '0;
        r_cnt[b] <= '0;
      end
    end else if (io_sdram_CKE) begin
      for (int b = 0; b < NB; b++) begin
        if (w_do_act && io_sdram_BA == BANK_WIDTH'(b)) begin
          r_open[b] <= 1'b1;
          r_row[b]  <= io_sdram_ADDR;
          r_cnt[b]  <= CNT_W'(T_RCD - 1);
        end else if (w_do_pre && (io_sdram_ADDR[10] ||
                     io_sdram_BA == BANK_WIDTH'(b))) begin
          r_open[b] <= 1'b0;
          r_cnt[b]  <= CNT_W'(T_RP - 1);
        end else if (r_cnt[b] != '0) begin
          r_cnt[b] <= r_cnt[b] - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_d_v <= 1'b0;
      r_d_q <= '0;
      r_s_v <= 1'b0;
      r_s_q <= '0;
      r_we  <= 1'b0;
      r_dq  <= '0;
    end else if (io_sdram_CKE) begin
      r_d_v <= w_do_rd && r_cl3;
      r_d_q <= w_rdata;
      if (w_do_rd && !r_cl3) begin
        r_s_v <= 1'b1;
        r_s_q <= w_rdata;
      end else begin
        r_s_v <= r_d_v;
        r_s_q <= r_d_q;
      end
      r_we <= r_s_v;
      if (r_s_v) r_dq <= r_s_q;
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_wr) begin
      for (int i = 0; i < NBYTE; i++) begin
        if (!io_sdram_DQM[i])
          r_mem[w_idx][8*i +: 8] <= io_sdram_DQ_read[8*i +: 8];
      end
    end
  end

  assign io_sdram_DQ_write       = r_dq;
  assign io_sdram_DQ_writeEnable = r_we;
  assign io_modeLoaded           = r_mode;
  assign io_error                = r_err;

endmodule

// File: tb/tb_sdram_responder.sv
// tb_sdram_responder: directed plus randomized command streams
// checked against a cycle-count reference model of the device.
module tb_sdram_responder;

  localparam int TRCD = 2;
  localparam int TRP  = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [12:0] p_addr = '0;
  logic [1:0]  p_ba = '0;
  logic [15:0] p_dq = '0;
  logic [1:0]  p_dqm = '0;
  logic        p_cas = 1'b1, p_ras = 1'b1, p_we = 1'b1;
  logic        p_cs = 1'b1, p_cke = 1'b1;
  logic [15:0] dq_out;
  logic        dq_oe, mode_ld, err;

  sdram_responder #(
    .BANK_WIDTH(2), .ROW_WIDTH(13), .COL_WIDTH(9),
    .DATA_WIDTH(16), .MEM_ADDR_WIDTH(10),
    .T_RCD(TRCD), .T_RP(TRP)
  ) dut (
    .clk(clk), .reset(reset),
    .io_sdram_ADDR(p_addr), .io_sdram_BA(p_ba),
    .io_sdram_DQ_read(p_dq), .io_sdram_DQ_write(dq_out),
    .io_sdram_DQ_writeEnable(dq_oe), .io_sdram_DQM(p_dqm),
    .io_sdram_CASn(p_cas), .io_sdram_RASn(p_ras),
    .io_sdram_WEn(p_we), .io_sdram_CSn(p_cs),
    .io_sdram_CKE(p_cke), .io_modeLoaded(mode_ld),
    .io_error(err)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail = 0;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // reference model: t counts enabled edges since reset
  int          t;
  bit          m_ml, m_err;
  int          m_cl;
  bit          m_open [4];
  int          m_row [4];
  int          m_rdy [4];
  logic [15:0] m_mem [int];
  bit          m_owe [int];
  bit          m_okn [int];
  logic [15:0] m_odq [int];

  function automatic bit any_open();
    for (int b = 0; b < 4; b++) if (m_open[b]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reset();
    t = 0; m_ml = 0; m_err = 0; m_cl = 3;
    for (int b = 0; b < 4; b++) begin
      m_open[b] = 0; m_row[b] = 0; m_rdy[b] = 0;
    end
    m_owe.delete(); m_okn.delete(); m_odq.delete();
  endtask

  task automatic model_step(bit cke, bit cs, bit ras, bit cas,
                            bit we, int ba, int a,
                            logic [15:0] d, int dqm);
    int idx, cf;
    logic [15:0] w;
    if (!cke) return;
    t++;
    if (cs) return;
    if (!m_ml && {ras, cas, we} != 3'b111 &&
        {ras, cas, we} != 3'b000) begin
      m_err = 1; return;
    end
    idx = ((ba << 22) + (m_row[ba] << 9) + (a % 512)) % 1024;
    case ({ras, cas, we})
      3'b000: begin
        if (any_open()) m_err = 1;
        else begin
          m_ml = 1;
          cf = (a >> 4) % 8;
          if (cf == 2 || cf == 3) m_cl = cf; else m_err = 1;
          if (a % 8 != 0) m_err = 1;
        end
      end
      3'b011: begin
        if (m_open[ba] || t < m_rdy[ba]) m_err = 1;
        else begin
          m_open[ba] = 1; m_row[ba] = a; m_rdy[ba] = t + TRCD;
        end
      end
      3'b101: begin
        if (!m_open[ba] || t < m_rdy[ba]) m_err = 1;
        else begin
          m_owe[t + m_cl - 1] = 1;
          m_okn[t + m_cl - 1] = m_mem.exists(idx);
          m_odq[t + m_cl - 1] = m_mem.exists(idx) ? m_mem[idx] : '0;
        end
      end
      3'b100: begin
        if (!m_open[ba] || t < m_rdy[ba]) m_err = 1;
        else if (dqm == 0 || m_mem.exists(idx)) begin
          w = m_mem.exists(idx) ? m_mem[idx] : 16'h0;
          if (dqm % 2 == 0) w[7:0] = d[7:0];
          if (dqm / 2 == 0) w[15:8] = d[15:8];
          m_mem[idx] = w;
        end else m_mem.delete(idx);
      end
      3'b010: begin
        for (int b = 0; b < 4; b++)
          if (a >= 1024 && (a / 1024) % 2 == 1 || b == ba) begin
            m_open[b] = 0; m_rdy[b] = t + TRP;
          end
      end
      3'b001: if (any_open()) m_err = 1;
      default: ;
    endcase
  endtask

  task automatic check_outputs();
    bit ew;
    ew = m_owe.exists(t);
    chk("we", dq_oe, ew);
    if (ew && m_okn[t]) chk("dq", dq_out, m_odq[t]);
    chk("modeLoaded", mode_ld, m_ml);
    chk("error", err, m_err);
  endtask

  task automatic cyc(bit cke, bit cs, bit ras, bit cas, bit we,
                     int ba, int a, logic [15:0] d, int dqm);
    @(negedge clk);
    p_cke = cke; p_cs = cs; p_ras = ras; p_cas = cas; p_we = we;
    p_ba = 2'(ba); p_addr = 13'(a); p_dq = d; p_dqm = 2'(dqm);
    @(posedge clk);
    model_step(cke, cs, ras, cas, we, ba, a, d, dqm);
    #1;
    check_outputs();
  endtask

  task automatic nop();         cyc(1,0,1,1,1,0,0,0,0); endtask
  task automatic lmr(int a);    cyc(1,0,0,0,0,0,a,0,0); endtask
  task automatic act(int b, int r); cyc(1,0,0,1,1,b,r,0,0); endtask
  task automatic rd(int b, int c);  cyc(1,0,1,0,1,b,c,0,0); endtask
  task automatic wr(int b, int c, logic [15:0] d, int m);
    cyc(1,0,1,0,0,b,c,d,m);
  endtask
  task automatic pre(int b, bit all);
    cyc(1,0,0,1,0,b,all ? 1024 : 0,0,0);
  endtask
  task automatic refr();        cyc(1,0,0,0,1,0,0,0,0); endtask
  task automatic nops(int n);
    for (int i = 0; i < n; i++) nop();
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    model_reset();
    chk("rst_we", dq_oe, 1'b0);
    chk("rst_dq", dq_out, 16'h0);
    chk("rst_modeLoaded", mode_ld, 1'b0);
    chk("rst_error", err, 1'b0);
    p_cke = 1; p_cs = 0; p_ras = 1; p_cas = 1; p_we = 1;
    @(negedge clk);
    reset = 1'b1;
  endtask

  function automatic bit legal(int op, int b);
    int tn;
    tn = t + 1;
    case (op)
      2:          return !m_open[b] && tn >= m_rdy[b];
      3, 4, 5, 6: return m_open[b] && tn >= m_rdy[b];
      8, 9:       return !any_open();
      default:    return 1'b1;
    endcase
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int op, b, r, c, m, a;
    bit all, cke, ras, cas, we;
    logic [15:0] d;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    chk("init_we", dq_oe, 1'b0);
    chk("init_dq", dq_out, 16'h0);
    chk("init_modeLoaded", mode_ld, 1'b0);
    chk("init_error", err, 1'b0);
    p_cs = 0;
    reset = 1'b1;

    lmr(12'h020);
    rd(0, 0);

    do_reset();
    lmr(12'h020);
    act(1, 12'h0A5);
    nop();
    wr(1, 12'h012, 16'hBEEF, 0);
    rd(1, 12'h012);
    nops(3);
    wr(1, 12'h020, 16'h1234, 0);
    wr(1, 12'h020, 16'hAB00, 1);
    rd(1, 12'h020);
    nops(3);
    pre(0, 1);
    nops(2);
    lmr(12'h030);
    act(2, 3);
    nop();
    for (int i = 0; i < 4; i++) wr(2, i, 16'h1111 * (i + 1), 0);
    for (int i = 0; i < 4; i++) rd(2, i);
    nops(5);

    do_reset();
    lmr(12'h020);
    act(0, 5);
    rd(0, 0);
    nops(3);
    do_reset();
    lmr(12'h020);
    act(0, 5);
    nops(2);
    act(0, 6);
    nops(2);

    do_reset();
    lmr(12'h030);
    act(0, 1);
    act(2, 1);
    nop();
    pre(0, 1);
    nop();
    refr();
    nops(2);

    do_reset();
    lmr(12'h021);
    do_reset();
    lmr(12'h020);
    lmr(12'h010);
    act(1, 12'h0A5);
    nops(2);
    rd(1, 12'h012);
    nops(3);

    do_reset();
    lmr(12'h030);
    act(1, 12'h0A5);
    nop();
    rd(1, 12'h012);
    nops(2);
    do_reset();

    lmr($urandom_range(2, 3) << 4);
    for (int i = 0; i < 800; i++) begin
      op  = $urandom_range(0, 9);
      b   = $urandom_range(0, 3);
      r   = $urandom_range(0, 3);
      c   = $urandom_range(0, 7);
      d   = 16'($urandom);
      m   = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
      all = ($urandom_range(0, 4) == 0);
      cke = ($urandom_range(0, 19) != 0);
      if (cke && !legal(op, b)) op = 0;
      a = 0;
      case (op)
        2:       begin {ras, cas, we} = 3'b011; a = r; end
        3, 4:    begin {ras, cas, we} = 3'b101; a = c; end
        5, 6:    begin {ras, cas, we} = 3'b100; a = c; end
        7:       begin {ras, cas, we} = 3'b010; a = all ? 1024 : 0; end
        8:       begin
                   {ras, cas, we} = 3'b000;
                   a = $urandom_range(2, 3) << 4;
                 end
        9:       {ras, cas, we} = 3'b001;
        default: {ras, cas, we} = 3'b111;
      endcase
      cyc(cke, 0, ras, cas, we, b, a, d, m);
    end
    nops(4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
